// File: rtl/iob_cache_repl_ctrl.sv
// iob_cache_repl_ctrl: sequences policy-state clear sweeps, hit updates and victim lookups for a cache replacement policy.
// Define IOB_CACHE_REPL_CTRL_RR_EN for round-robin hit/alloc arbitration; the default gives alloc fixed priority.
module iob_cache_repl_ctrl #(
  parameter int N_WAYS   = 8,
  parameter int NLINES_W = 7,
  parameter int NWAYS_W  = $clog2(N_WAYS)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                flush_i,
  input  logic                hit_valid_i,
  output logic                hit_ready_o,
  input  logic [N_WAYS-1:0]   hit_way_i,
  input  logic [NLINES_W-1:0] hit_line_i,
  input  logic                alloc_valid_i,
  output logic                alloc_ready_o,
  input  logic [NLINES_W-1:0] alloc_line_i,
  output logic                victim_valid_o,
  output logic [N_WAYS-1:0]   victim_way_o,
  output logic [NWAYS_W-1:0]  victim_bin_o,
  output logic                busy_o,
  output logic [NLINES_W-1:0] pol_line_o,
  output logic [N_WAYS-1:0]   pol_way_hit_o,
  output logic                pol_we_o,
  output logic                pol_rst_o,
  input  logic [N_WAYS-1:0]   pol_sel_i,
  input  logic [NWAYS_W-1:0]  pol_sel_bin_i
);
  typedef enum logic [1:0] {INIT, IDLE, LOOKUP, UPDATE} state_t;
  state_t                state_q;
  logic [NLINES_W-1:0]   cnt_q, line_q;
  logic [N_WAYS-1:0]     way_q, vic_way_q;
  logic [NWAYS_W-1:0]    vic_bin_q;
  logic                  pend_q, vic_valid_q;
  logic                  idle, hit_gnt, alloc_gnt;
  // A flush in IDLE pre-empts any grant in that cycle.
  assign idle = rst_n_i && state_q == IDLE && !flush_i;
`ifdef IOB_CACHE_REPL_CTRL_RR_EN
  logic rr_q;
  assign hit_ready_o   = idle && (!rr_q || !alloc_valid_i);
  assign alloc_ready_o = idle && (rr_q || !hit_valid_i);
  always_ff @(posedge clk_i)
    if (!rst_n_i) rr_q <= 1'b0;
    else if (hit_gnt) rr_q <= 1'b1;
    else if (alloc_gnt) rr_q <= 1'b0;
`else
  assign hit_ready_o   = idle && !alloc_valid_i;
  assign alloc_ready_o = idle;
`endif
  assign hit_gnt   = hit_valid_i && hit_ready_o;
  assign alloc_gnt = alloc_valid_i && alloc_ready_o;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      line_q      <= '0;
      way_q       <= '0;
      vic_way_q   <= '0;
      vic_bin_q   <= '0;
      pend_q      <= 1'b0;
      vic_valid_q <= 1'b0;
    end else begin
      vic_valid_q <= 1'b0;
      case (state_q)
        INIT: begin
          cnt_q <= (flush_i || cnt_q == '1) ? '0 : cnt_q + 1'b1;
          if (!flush_i && cnt_q == '1) state_q <= IDLE;
        end
        IDLE:
          if (flush_i) state_q <= INIT;
          else if (hit_gnt) begin
            line_q  <= hit_line_i;
            way_q   <= hit_way_i;
            state_q <= UPDATE;
          end else if (alloc_gnt) begin
            line_q  <= alloc_line_i;
            state_q <= LOOKUP;
          end
        LOOKUP: begin
          pend_q      <= pend_q || flush_i;
          way_q       <= pol_sel_i;
          vic_way_q   <= pol_sel_i;
          vic_bin_q   <= pol_sel_bin_i;
          vic_valid_q <= 1'b1;
          state_q     <= UPDATE;
        end
        UPDATE: begin
          pend_q  <= 1'b0;
          state_q <= (pend_q || flush_i) ? INIT : IDLE;
        end
      endcase
    end
  end
  // Outputs are gated by reset so a cycle held in reset never writes or reports a victim.
  assign victim_valid_o = rst_n_i && vic_valid_q;
  assign victim_way_o   = vic_way_q;
  assign victim_bin_o   = vic_bin_q;
  assign busy_o         = !rst_n_i || state_q != IDLE;
  assign pol_we_o       = rst_n_i && (state_q == INIT || state_q == UPDATE);
  assign pol_rst_o      = rst_n_i && state_q == INIT;
  assign pol_line_o     = state_q == INIT ? cnt_q : (state_q == LOOKUP || state_q == UPDATE) ? line_q : '0;
  assign pol_way_hit_o  = state_q == UPDATE ? way_q : '0;
endmodule

// File: doc/iob_cache_repl_ctrl.md
IOB_CACHE_REPL_CTRL -- requirements
Module: iob_cache_repl_ctrl

Interface
REQ-001 Parameter N_WAYS, default 8, number of cache ways (power of two, >=2).
REQ-002 Parameter NLINES_W, default 7, line-address width; number of lines = 2**NLINES_W.
REQ-003 Parameter NWAYS_W, default $clog2(N_WAYS), binary way-index width.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset, with ports named as follows:
- clk_i  in  1  clock, all state on rising edge.
- rst_n_i  in  1  synchronous active-low reset.
REQ-005 Ports SHALL be:
- flush_i  in  1  pulse; request a replacement-state clear sweep.
- hit_valid_i  in  1  hit-update request valid.
- hit_ready_o  out  1  hit-update request accepted.
- hit_way_i  in  N_WAYS  one-hot hit way.
- hit_line_i  in  NLINES_W  line of hit.
- alloc_valid_i  in  1  victim-allocation request valid.
- alloc_ready_o  out  1  allocation request accepted.
- alloc_line_i  in  NLINES_W  line needing a victim.
- victim_valid_o  out  1  one-cycle pulse; victim result valid.
- victim_way_o  out  N_WAYS  one-hot victim way.
- victim_bin_o  out  NWAYS_W  binary victim way.
- busy_o  out  1  sweep or transaction in progress.
- pol_line_o  out  NLINES_W  line address to policy state memory.
- pol_way_hit_o  out  N_WAYS  way_hit to policy block.
- pol_we_o  out  1  policy state write enable.
- pol_rst_o  out  1  policy-state clear data select during sweep.
- pol_sel_i  in  N_WAYS  policy one-hot way_select (combinational read of pol_line_o).
- pol_sel_bin_i  in  NWAYS_W  policy binary way_select.

Function
REQ-006 FSM states: INIT, IDLE, LOOKUP, UPDATE.
REQ-007 INIT: sweep counter 0..2**NLINES_W-1, one line per cycle; pol_line_o=counter, pol_we_o=1, pol_rst_o=1, pol_way_hit_o=0; after last line go IDLE (sweep = 2**NLINES_W cycles).
REQ-008 In INIT both ready outputs SHALL be 0 and busy_o=1.
REQ-009 IDLE: ready outputs reflect arbitration grant; request accepted when valid&ready in the same cycle; at most one grant per cycle.
REQ-010 Accepted hit: latch hit_line_i/hit_way_i, go UPDATE; UPDATE drives pol_line_o=latched line, pol_way_hit_o=latched way, pol_we_o=1 for one cycle, then IDLE.
REQ-011 Accepted alloc: latch alloc_line_i, go LOOKUP; LOOKUP drives pol_line_o=latched line, pol_we_o=0, captures pol_sel_i/pol_sel_bin_i into victim registers.
REQ-012 Alloc UPDATE: pol_way_hit_o=captured victim, pol_we_o=1; victim_valid_o=1 in that cycle with victim_way_o/victim_bin_o = captured values (latency accept->victim_valid_o = 2 cycles).
REQ-013 victim_way_o/victim_bin_o SHALL hold their last value until next alloc UPDATE.
REQ-014 busy_o=1 in INIT, LOOKUP, UPDATE; 0 in IDLE.
REQ-015 Outside INIT/UPDATE pol_we_o=0; outside INIT pol_rst_o=0; in IDLE pol_line_o=0 and pol_way_hit_o=0.
REQ-016 hit_way_i all-zero accepted: UPDATE still writes (policy retains state); no error.
REQ-017 flush_i in IDLE: go INIT next cycle, flush has priority over requests that cycle (no grant).
REQ-018 flush_i in LOOKUP/UPDATE: recorded in a pending flag; current transaction completes (incl. victim_valid_o), then INIT instead of IDLE.
REQ-019 flush_i in INIT: sweep counter restarts at 0.
REQ-020 Back-to-back: a request may be granted in the IDLE cycle after UPDATE; no combinational path valid->ready except via grant logic.

Reset
REQ-021 On rst_n_i=0 at a rising edge: state=INIT, sweep counter=0, pending flush=0, arbitration pointer=hit, victim registers=0, victim_valid_o=0; mid-transaction reset abandons the transaction without victim_valid_o.
REQ-022 During reset cycle outputs: ready=0, busy_o=1, pol_we_o=0.

Configuration
REQ-023 Macro IOB_CACHE_REPL_CTRL_RR_EN defined: round-robin between hit and alloc on simultaneous valid; pointer toggles to the other requester after each grant.
REQ-024 Macro undefined: fixed priority, alloc wins over hit; hit granted only when alloc_valid_i=0.

Verification
REQ-025 N_WAYS=4, NLINES_W=3, release reset -> pol_we_o=pol_rst_o=1 for 8 cycles, pol_line_o 0..7, then busy_o=0.
REQ-026 Alloc line 5, pol_sel_i=4'b0100 -> victim_valid_o 2 cycles after accept, victim_way_o=4'b0100, victim_bin_o=2, UPDATE writes line 5 with way_hit 4'b0100.
REQ-027 Hit and alloc valid together twice: RR_EN -> hit, alloc order; undefined -> alloc, alloc, then hit.
REQ-028 flush_i during LOOKUP of line 3 -> victim_valid_o still pulses, then 8-cycle sweep starting line 0.
REQ-029 rst_n_i=0 during alloc LOOKUP -> no victim_valid_o, INIT sweep restarts at line 0.
